number_entry_buffer: RTL and testbench
======================================

NUMBER_ENTRY_BUFFER -- requirements
Module: number_entry_buffer

Interface
REQ-001 The block SHALL have one parameter: MAX_DIGITS, 10, maximum BCD digits held (1..10).
REQ-002 The block SHALL have port clk_100MHz, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port key_valid, input, 1, key request valid.
REQ-005 The block SHALL have port key_code, input, 4, key code: 0-9 digit, 4'hA clear, 4'hB backspace, 4'hC enter, 4'hD-4'hF reserved.
REQ-006 The block SHALL have port key_ready, output, 1, block can accept a key this cycle.
REQ-007 The block SHALL have port numActual, output, 40, displayed number as 10 packed BCD digits; most recent digit in [3:0].
REQ-008 The block SHALL have port counterTotal, output, 4, count of digits held (0..MAX_DIGITS).
REQ-009 The block SHALL have port operand, output, 40, BCD operand latched on enter.
REQ-010 The block SHALL have port operand_valid, output, 1, operand available to the downstream consumer.
REQ-011 The block SHALL have port operand_ready, input, 1, downstream consumer accepts operand.
REQ-012 The block SHALL have port overflow, output, 1, one-cycle pulse when a digit is rejected because the buffer is full.

Function
REQ-013 A key transfer SHALL occur on a rising edge where key_valid and key_ready are both 1; key_valid without key_ready has no effect.
REQ-014 All outputs SHALL be registered; the effect of a transfer SHALL be visible the cycle after the accepting edge (latency 1).
REQ-015 FSM states SHALL be ENTRY (key_ready=1, operand_valid=0) and HOLD (key_ready=0, operand_valid=1).
REQ-016 ENTRY->HOLD SHALL occur on an enter transfer; HOLD->ENTRY SHALL occur on an edge with operand_ready=1; no other transitions exist.
REQ-017 A digit transfer with counterTotal<MAX_DIGITS SHALL set numActual={numActual[35:0],digit} and increment counterTotal.
REQ-018 Digit 0 with counterTotal=0 SHALL be consumed with no state change and no overflow, so no leading zeros are stored.
REQ-019 A digit transfer with counterTotal=MAX_DIGITS SHALL leave numActual and counterTotal unchanged and assert overflow for exactly one cycle.
REQ-020 Backspace SHALL set numActual={4'h0,numActual[39:4]} and decrement counterTotal; with counterTotal=0 it SHALL be a no-op.
REQ-021 Clear SHALL zero numActual and counterTotal in one cycle.
REQ-022 Enter SHALL copy numActual to operand, and zero numActual and counterTotal on the same edge; enter with counterTotal=0 SHALL deliver operand=0.
REQ-023 Reserved codes SHALL be consumed with no state change.
REQ-024 operand SHALL remain stable while operand_valid=1; after the handoff it SHALL hold its value while operand_valid=0.
REQ-025 counterTotal SHALL never exceed MAX_DIGITS, and digit positions at or above counterTotal SHALL read 0.

Reset
REQ-026 While reset_n=0, regardless of clock, the FSM SHALL be in ENTRY, numActual=0, counterTotal=0, operand=0, operand_valid=0, overflow=0 and key_ready=1.
REQ-027 Reset asserted while in HOLD SHALL discard the pending operand without a handshake.
REQ-028 Reset deassertion SHALL be synchronised externally; the first transfer SHALL be accepted on the first edge after release.

Structure
REQ-029 A shared package SHALL hold the key-code constants (KEY_CLEAR, KEY_BACK, KEY_ENTER), the ENTRY/HOLD state encoding and the default MAX_DIGITS.
REQ-030 The BCD shift/backspace register with its counter SHALL be one sub-module, bcd_digit_shifter; the FSM and the handshake SHALL reside in number_entry_buffer.

Verification
REQ-031 Reset, then keys 1,2,3 -> numActual=40'h0000000123, counterTotal=3, overflow never set.
REQ-032 Keys 0,0,7 from empty -> numActual=40'h7, counterTotal=1; backspace twice -> 0 and 0, no underflow.
REQ-033 Eleven digit-9 keys -> numActual=40'h9999999999, counterTotal=10, overflow high for exactly one cycle after the 11th key.
REQ-034 Keys 4,2 then enter with operand_ready=0 for 5 cycles -> operand=40'h42, operand_valid held, key_ready=0, numActual=0; keys offered meanwhile are ignored; operand_ready=1 -> operand_valid=0 and key_ready=1 next cycle.
REQ-035 Keys 5,6 then clear -> all outputs 0; enter with nothing held -> operand=0 and operand_valid=1.
REQ-036 reset_n pulsed low mid-clock while in HOLD -> outputs match their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/number_entry_buffer_pkg.sv
// Shared key codes, FSM encoding and shifter operations for the number entry buffer.
package number_entry_buffer_pkg;

  localparam int MAX_DIGITS_DEFAULT = 10;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_BACK,
    OP_CLEAR
  } shift_op_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/number_entry_buffer_bcd_digit_shifter.sv
// Packed BCD digit register with its occupancy counter: push, backspace, clear,
// with leading-zero suppression and a one-cycle overflow pulse when full.
module bcd_digit_shifter
  import number_entry_buffer_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  shift_op_t   op,
  input  logic [3:0]  digit,
  output logic [39:0] digits,
  output logic [3:0]  count,
  output logic        overflow
);

  localparam logic [3:0] MAX_COUNT = 4'(MAX_DIGITS);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (count == MAX_COUNT) begin
            overflow <= 1'b1;
          end else if (count != 4'd0 || digit != 4'd0) begin
            digits <= {digits[35:0], digit};
            count  <= count + 4'd1;
          end
        end
        OP_BACK: begin
          if (count != 4'd0) begin
            digits <= {4'h0, digits[39:4]};
            count  <= count - 4'd1;
          end
        end
        OP_CLEAR: begin
          digits <= '0;
          count  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/number_entry_buffer.sv
// Keypad number entry: accepts digit/edit keys into a BCD buffer and hands the
// entered number to a downstream consumer with a valid/ready handshake.
module number_entry_buffer
  import number_entry_buffer_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [39:0] numActual,
  output logic [3:0]  counterTotal,
  output logic [39:0] operand,
  output logic        operand_valid,
  input  logic        operand_ready,
  output logic        overflow
);

  state_t    state;
  shift_op_t op;
  logic      take;

  assign take = key_valid && key_ready;

  // NOTE: op gets a default before any branch so this block stays purely
  // combinational and no latch is inferred.
  always_comb begin
    op = OP_NONE;
    if (take) begin
      if (is_digit(key_code))                              op = OP_PUSH;
      else if (key_code == KEY_BACK)                       op = OP_BACK;
      else if (key_code == KEY_CLEAR || key_code == KEY_ENTER) op = OP_CLEAR;
    end
  end

  bcd_digit_shifter #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_shifter (
    .clk      (clk_100MHz),
    .rst_n    (reset_n),
    .op       (op),
    .digit    (key_code),
    .digits   (numActual),
    .count    (counterTotal),
    .overflow (overflow)
  );

  // Enter samples the buffer before the shifter clears it on the same edge.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ENTRY;
      key_ready     <= 1'b1;
      operand_valid <= 1'b0;
      operand       <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (take && key_code == KEY_ENTER) begin
            state         <= HOLD;
            key_ready     <= 1'b0;
            operand_valid <= 1'b1;
            operand       <= numActual;
          end
        end
        HOLD: begin
          if (operand_ready) begin
            state         <= ENTRY;
            key_ready     <= 1'b1;
            operand_valid <= 1'b0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_number_entry_buffer.sv
// Directed and randomized stimulus against a digit-queue reference model of the
// number entry buffer.
module tb_number_entry_buffer;

  localparam int MAX = 10;

  logic        clk_100MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_ready;
  logic [39:0] numActual;
  logic [3:0]  counterTotal;
  logic [39:0] operand;
  logic        operand_valid;
  logic        operand_ready = 1'b0;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: q[0] is the most recently entered digit.
  logic [3:0]  q[$];
  bit          m_hold;
  logic [39:0] m_operand;
  logic        m_ovf;

  always #5 clk_100MHz = ~clk_100MHz;

  number_entry_buffer #(.MAX_DIGITS(MAX)) dut (
    .clk_100MHz    (clk_100MHz),
    .reset_n       (reset_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ready     (key_ready),
    .numActual     (numActual),
    .counterTotal  (counterTotal),
    .operand       (operand),
    .operand_valid (operand_valid),
    .operand_ready (operand_ready),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] model_number();
    logic [39:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = v | (40'(q[i]) << (4 * i));
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_hold    = 1'b0;
    m_operand = '0;
    m_ovf     = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".key_ready"},     40'(key_ready),     40'(!m_hold));
    check({tag, ".operand_valid"}, 40'(operand_valid), 40'(m_hold));
    check({tag, ".numActual"},     numActual,          model_number());
    check({tag, ".counterTotal"},  40'(counterTotal),  40'(q.size()));
    check({tag, ".operand"},       operand,            m_operand);
    check({tag, ".overflow"},      40'(overflow),      40'(m_ovf));
  endtask

  // Apply one cycle of inputs (called just after a falling edge), advance the
  // model by the same rules, then compare on the next falling edge.
  task automatic step(input logic v, input logic [3:0] code, input logic rdy, input string tag);
    key_valid     = v;
    key_code      = code;
    operand_ready = rdy;
    m_ovf = 1'b0;
    if (!m_hold) begin
      if (v) begin
        if (code <= 4'd9) begin
          if (q.size() == MAX)                   m_ovf = 1'b1;
          else if (q.size() != 0 || code != 4'd0) q.push_front(code);
        end else if (code == 4'hB) begin
          if (q.size() != 0) void'(q.pop_front());
        end else if (code == 4'hA) begin
          q.delete();
        end else if (code == 4'hC) begin
          m_operand = model_number();
          q.delete();
          m_hold = 1'b1;
        end
      end
    end else if (rdy) begin
      m_hold = 1'b0;
    end
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    check_all("reset");
    reset_n = 1'b1;

    // Digits 1,2,3 accepted on the first edges after release.
    step(1, 4'd1, 0, "k1");
    step(1, 4'd2, 0, "k2");
    step(1, 4'd3, 0, "k3");
    check("seq123.num", numActual, 40'h0000000123);
    step(0, 4'd5, 0, "idle");

    // Leading zeros dropped, backspace stops at empty.
    step(1, 4'hA, 0, "clr");
    step(1, 4'd0, 0, "z0");
    step(1, 4'd0, 0, "z1");
    step(1, 4'd7, 0, "k7");
    check("lead0.num", numActual, 40'h7);
    step(1, 4'hB, 0, "bs1");
    step(1, 4'hB, 0, "bs2");
    check("bs.count", 40'(counterTotal), 40'd0);

    // Fill to capacity; the 11th digit overflows for one cycle only.
    for (int i = 0; i < 11; i++) step(1, 4'd9, 0, "nine");
    check("full.num", numActual, 40'h9999999999);
    step(0, 4'd0, 0, "after_ovf");
    step(1, 4'hE, 0, "reserved");

    // Enter with a stalled consumer; keys meanwhile are ignored.
    step(1, 4'hA, 0, "clr2");
    step(1, 4'd4, 0, "k4");
    step(1, 4'd2, 0, "k2b");
    step(1, 4'hC, 0, "enter42");
    for (int i = 0; i < 5; i++) step(1, 4'd7, 0, "stall");
    check("hold.operand", operand, 40'h42);
    step(0, 4'd0, 1, "handoff");
    check("handoff.key_ready", 40'(key_ready), 40'd1);
    step(1, 4'd3, 0, "post_handoff");

    // Clear, then enter an empty buffer.
    step(1, 4'd5, 0, "k5");
    step(1, 4'd6, 0, "k6");
    step(1, 4'hA, 0, "clr56");
    step(1, 4'hC, 0, "enter0");
    check("enter0.operand", operand, 40'h0);

    // Asynchronous reset mid-cycle while holding an operand.
    step(1, 4'd1, 0, "hold_more");
    #2;
    key_valid = 1'b1;
    key_code  = 4'd8;
    reset_n   = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check_all("rst_held");
    reset_n = 1'b1;
    step(1, 4'd8, 0, "first_after_rst");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic       v;
      logic [3:0] c;
      logic       r;
      v = ($urandom_range(0, 3) != 0);
      c = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 2) == 0);
      step(v, c, r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
